mem_port_arbiter: RTL and testbench

Arbitrates a single-port, fixed-latency word memory between the IF-stage instruction fetch and the MEM-stage load/store, which is fed from the EX/MEM pipeline register outputs (aluop, mem_addr, reg2). It sequences each access over ACCESS_CYCLES cycles and returns data with a one-cycle ack. It also raises stall_req to the pipeline controller while any request is outstanding. MEM has fixed priority over IF, because it carries the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM port seen by mem_port_arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 20
) ();
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_sel;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              stall_req;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack, ram_ce, ram_we, ram_addr, ram_sel,
               ram_wdata, stall_req
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack, ram_ce, ram_we, ram_addr, ram_sel,
               ram_wdata, stall_req
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency word RAM between instruction fetch and load/store.
// MEM has fixed priority; each access holds ram_ce for ACCESS_CYCLES, then acks for one cycle.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StAccMem, StAccIf, StAck} state_e;

    localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]        ram_sel_q, ram_sel_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_sel_q   <= 4'h0;
            ram_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_sel_q   <= ram_sel_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_ce_d    = ram_ce_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_sel_d   = ram_sel_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (bus.mem_req) begin
                    state_d     = StAccMem;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = bus.mem_we;
                    ram_addr_d  = bus.mem_addr[ADDR_W+1:2];
                    ram_sel_d   = bus.mem_sel;
                    ram_wdata_d = bus.mem_wdata;
                end else if (bus.if_req) begin
                    state_d    = StAccIf;
                    ram_ce_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = bus.if_addr[ADDR_W+1:2];
                    ram_sel_d  = 4'hF;
                end
            end
            StAccMem, StAccIf: begin
                if (cnt_q == LastCnt) begin
                    state_d  = StAck;
                    cnt_d    = 4'd0;
                    ram_ce_d = 1'b0;
                    ram_we_d = 1'b0;
                    if (state_q == StAccMem) begin
                        mem_ack_d = 1'b1;
                        // Stores leave the last load value visible.
                        if (!ram_we_q) begin
                            mem_rdata_d = bus.ram_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAck: begin
                // No grant here, so a requester dropping after its ack is never re-served.
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_sel   = ram_sel_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.stall_req = (bus.if_req & ~if_ack_q) | (bus.mem_req & ~mem_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level memory model; a second instance covers ACCESS_CYCLES = 1.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 20;
    localparam int AC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    // RAM model behind the main instance; pokes preload words.
    logic [31:0] ram_mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = 8'h0;
    logic [31:0] poke_data = 32'h0;

    assign bus.ram_rdata  = ram_mem[bus.ram_addr[7:0]];
    assign bus1.ram_rdata = {12'hC0D, bus1.ram_addr};

    always @(posedge clk) begin
        if (poke_en) begin
            ram_mem[poke_addr] <= poke_data;
        end else if (bus.ram_ce && bus.ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_sel[b]) ram_mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
    end

    int if_ack_cnt = 0;
    int mem_ack_cnt = 0;
    always @(posedge clk) begin
        if (bus.if_ack)  if_ack_cnt  <= if_ack_cnt + 1;
        if (bus.mem_ack) mem_ack_cnt <= mem_ack_cnt + 1;
    end

    logic [31:0] exp_mem_rdata = 32'h0;
    logic [31:0] ref_mem [32];

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.ram_ce, bus.ram_we, bus.if_ack, bus.mem_ack, bus.stall_req} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.ram_ce, bus.ram_we, bus.if_ack, bus.mem_ack, bus.stall_req});
        end
        vectors++;
        if ({bus.ram_addr, bus.ram_sel, bus.ram_wdata} !== 56'h0) begin
            miscompares++;
            $display("FAIL reset_ram_bus: got %h want 0", {bus.ram_addr, bus.ram_sel, bus.ram_wdata});
        end
        vectors++;
        if ({bus.if_rdata, bus.mem_rdata, bus1.ram_ce, bus1.if_ack} !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 0",
                     {bus.if_rdata, bus.mem_rdata, bus1.ram_ce, bus1.if_ack});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        poke(8'd4, 32'h2401_0005);
        bus.if_addr = 32'h0000_0010;
        bus.if_req  = 1'b1;
        #1;
        vectors++;
        if (bus.stall_req !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_stall_t0: got %b want 1", bus.stall_req);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (k <= AC) begin
                if ({bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_sel, bus.if_ack, bus.stall_req} !==
                    {1'b1, 1'b0, 20'h4, 4'hF, 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL fetch_access k=%0d: got %h want %h", k,
                             {bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_sel, bus.if_ack,
                              bus.stall_req}, {1'b1, 1'b0, 20'h4, 4'hF, 1'b0, 1'b1});
                end
            end else if (k == AC + 1) begin
                if ({bus.ram_ce, bus.if_ack, bus.if_rdata, bus.stall_req} !==
                    {1'b0, 1'b1, 32'h2401_0005, 1'b0}) begin
                    miscompares++;
                    $display("FAIL fetch_ack: got %h want %h",
                             {bus.ram_ce, bus.if_ack, bus.if_rdata, bus.stall_req},
                             {1'b0, 1'b1, 32'h2401_0005, 1'b0});
                end
                bus.if_req = 1'b0;
            end else begin
                if ({bus.if_ack, bus.if_rdata, bus.ram_ce} !== {1'b0, 32'h2401_0005, 1'b0}) begin
                    miscompares++;
                    $display("FAIL fetch_hold: got %h want %h", {bus.if_ack, bus.if_rdata, bus.ram_ce},
                             {1'b0, 32'h2401_0005, 1'b0});
                end
            end
        end
    endtask

    task automatic test_store();
        poke(8'h40, 32'h1122_3344);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_0100;
        bus.mem_sel   = 4'b0011;
        bus.mem_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= AC + 1; k++) begin
            @(negedge clk);
            vectors++;
            if (k <= AC) begin
                if ({bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_sel, bus.ram_wdata, bus.mem_ack} !==
                    {1'b1, 1'b1, 20'h40, 4'h3, 32'hDEAD_BEEF, 1'b0}) begin
                    miscompares++;
                    $display("FAIL store_access k=%0d: got %h want %h", k,
                             {bus.ram_ce, bus.ram_we, bus.ram_addr, bus.ram_sel, bus.ram_wdata,
                              bus.mem_ack}, {1'b1, 1'b1, 20'h40, 4'h3, 32'hDEAD_BEEF, 1'b0});
                end
            end else begin
                if ({bus.ram_ce, bus.ram_we, bus.mem_ack, bus.mem_rdata} !==
                    {1'b0, 1'b0, 1'b1, exp_mem_rdata}) begin
                    miscompares++;
                    $display("FAIL store_ack: got %h want %h",
                             {bus.ram_ce, bus.ram_we, bus.mem_ack, bus.mem_rdata},
                             {1'b0, 1'b0, 1'b1, exp_mem_rdata});
                end
                bus.mem_req = 1'b0;
                bus.mem_we  = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (ram_mem[8'h40] !== 32'h1122_BEEF) begin
            miscompares++;
            $display("FAIL store_ram_content: got %h want 1122beef", ram_mem[8'h40]);
        end
    endtask

    task automatic test_contention();
        logic exp_mem_ce, exp_if_ce;
        poke(8'h80, 32'h0000_00AA);
        poke(8'h08, 32'h1357_9BDF);
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0000_0200;
        bus.if_addr  = 32'h0000_0020;
        bus.mem_req  = 1'b1;
        bus.if_req   = 1'b1;
        for (int k = 1; k <= 2 * AC + 4; k++) begin
            @(negedge clk);
            exp_mem_ce = (k >= 1) && (k <= AC);
            exp_if_ce  = (k >= AC + 3) && (k <= 2 * AC + 2);
            vectors++;
            if ({bus.ram_ce, bus.mem_ack, bus.if_ack} !==
                {exp_mem_ce | exp_if_ce, k == AC + 1, k == 2 * AC + 3}) begin
                miscompares++;
                $display("FAIL contention_ctrl k=%0d: got %b want %b", k,
                         {bus.ram_ce, bus.mem_ack, bus.if_ack},
                         {exp_mem_ce | exp_if_ce, k == AC + 1, k == 2 * AC + 3});
            end
            if (exp_mem_ce || exp_if_ce) begin
                vectors++;
                if (bus.ram_addr !== (exp_mem_ce ? 20'h80 : 20'h8)) begin
                    miscompares++;
                    $display("FAIL contention_addr k=%0d: got %h want %h", k, bus.ram_addr,
                             exp_mem_ce ? 20'h80 : 20'h8);
                end
            end
            if (k == AC + 1) begin
                exp_mem_rdata = 32'h0000_00AA;
                vectors++;
                if (bus.mem_rdata !== exp_mem_rdata) begin
                    miscompares++;
                    $display("FAIL contention_mem_rdata: got %h want %h", bus.mem_rdata, exp_mem_rdata);
                end
                bus.mem_req = 1'b0;
            end
            if (k == 2 * AC + 3) begin
                vectors++;
                if (bus.if_rdata !== 32'h1357_9BDF) begin
                    miscompares++;
                    $display("FAIL contention_if_rdata: got %h want 13579bdf", bus.if_rdata);
                end
                bus.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int last;
        bit got;
        for (int i = 0; i < 4; i++) poke(8'(9 + i), 32'hB000_0000 + 32'(i));
        base = if_ack_cnt;
        last = 0;
        bus.if_addr = 32'(9) << 2;
        bus.if_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                if (bus.if_ack) got = 1'b1;
            end
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL b2b_timeout fetch %0d: got no ack want ack", i);
            end else begin
                vectors++;
                if (bus.if_rdata !== 32'hB000_0000 + 32'(i)) begin
                    miscompares++;
                    $display("FAIL b2b_rdata fetch %0d: got %h want %h", i, bus.if_rdata,
                             32'hB000_0000 + 32'(i));
                end
                if (i > 0) begin
                    vectors++;
                    if (cyc - last != 4) begin
                        miscompares++;
                        $display("FAIL b2b_interval fetch %0d: got %0d want 4", i, cyc - last);
                    end
                end
                last = cyc;
            end
            bus.if_addr = 32'(10 + i) << 2;
        end
        bus.if_req = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (if_ack_cnt - base != 4) begin
            miscompares++;
            $display("FAIL b2b_ack_count: got %0d want 4", if_ack_cnt - base);
        end
    endtask

    task automatic test_reset_mid_access();
        int base;
        base = mem_ack_cnt;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0000_0200;
        bus.mem_req  = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.ram_ce !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre_ce: got %b want 1", bus.ram_ce);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.ram_ce, bus.ram_we, bus.mem_ack, bus.ram_addr, bus.mem_rdata} !== 55'h0) begin
            miscompares++;
            $display("FAIL rst_mid_immediate: got %h want 0",
                     {bus.ram_ce, bus.ram_we, bus.mem_ack, bus.ram_addr, bus.mem_rdata});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (mem_ack_cnt != base || bus.ram_ce !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_no_ack: got acks %0d ce %b want acks 0 ce 0",
                     mem_ack_cnt - base, bus.ram_ce);
        end
        rst = 1'b1;
        exp_mem_rdata = 32'h0;
        for (int k = 1; k <= AC + 1; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus.ram_ce, bus.mem_ack} !== {k <= AC, k == AC + 1}) begin
                miscompares++;
                $display("FAIL rst_mid_reaccess k=%0d: got %b want %b", k,
                         {bus.ram_ce, bus.mem_ack}, {k <= AC, k == AC + 1});
            end
            if (k == AC + 1) begin
                exp_mem_rdata = 32'h0000_00AA;
                vectors++;
                if (bus.mem_rdata !== exp_mem_rdata) begin
                    miscompares++;
                    $display("FAIL rst_mid_rdata: got %h want %h", bus.mem_rdata, exp_mem_rdata);
                end
                bus.mem_req = 1'b0;
            end
        end
        @(negedge clk);
        vectors++;
        if (mem_ack_cnt - base != 1) begin
            miscompares++;
            $display("FAIL rst_mid_ack_count: got %0d want 1", mem_ack_cnt - base);
        end
    endtask

    task automatic test_single_cycle();
        bus1.if_addr = 32'h0001_2340;
        bus1.if_req  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus1.ram_ce, bus1.if_ack} !== {k == 1, k == 2}) begin
                miscompares++;
                $display("FAIL ac1_ctrl k=%0d: got %b want %b", k, {bus1.ram_ce, bus1.if_ack},
                         {k == 1, k == 2});
            end
            if (k == 1) begin
                vectors++;
                if (bus1.ram_addr !== 20'h048D0) begin
                    miscompares++;
                    $display("FAIL ac1_addr: got %h want 048d0", bus1.ram_addr);
                end
            end
            if (k == 2) begin
                vectors++;
                if (bus1.if_rdata !== 32'hC0D0_48D0) begin
                    miscompares++;
                    $display("FAIL ac1_rdata: got %h want c0d048d0", bus1.if_rdata);
                end
                bus1.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int kind, iw, mw, if_at, mem_at, last;
        logic we;
        logic [3:0] sel;
        logic [31:0] wd, d;
        bit if_pend, mem_pend;
        for (int w = 0; w < 32; w++) begin
            d = $urandom;
            poke(8'(w), d);
            ref_mem[w] = d;
        end
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            iw   = int'($urandom_range(0, 31));
            mw   = int'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 1));
            sel  = 4'($urandom_range(1, 15));
            wd   = $urandom;
            if_pend  = (kind != 1);
            mem_pend = (kind != 0);
            // MEM always goes first; IF then waits for ACK plus one IDLE cycle.
            mem_at = mem_pend ? AC + 1 : 0;
            if_at  = if_pend ? (mem_pend ? 2 * AC + 3 : AC + 1) : 0;
            last   = (if_at > mem_at ? if_at : mem_at) + 1;
            bus.if_addr   = 32'(iw) << 2;
            bus.mem_addr  = 32'(mw) << 2;
            bus.mem_we    = we;
            bus.mem_sel   = sel;
            bus.mem_wdata = wd;
            bus.if_req    = if_pend;
            bus.mem_req   = mem_pend;
            for (int k = 1; k <= last; k++) begin
                @(negedge clk);
                vectors++;
                if ({bus.if_ack, bus.mem_ack} !== {k == if_at, k == mem_at}) begin
                    miscompares++;
                    $display("FAIL rand_ack it=%0d k=%0d: got %b want %b", it, k,
                             {bus.if_ack, bus.mem_ack}, {k == if_at, k == mem_at});
                end
                vectors++;
                if (bus.stall_req !== ((if_pend && k != if_at) || (mem_pend && k != mem_at))) begin
                    miscompares++;
                    $display("FAIL rand_stall it=%0d k=%0d: got %b want %b", it, k, bus.stall_req,
                             (if_pend && k != if_at) || (mem_pend && k != mem_at));
                end
                if (k == mem_at) begin
                    if (we) begin
                        for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[mw][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        exp_mem_rdata = ref_mem[mw];
                    end
                    vectors++;
                    if (bus.mem_rdata !== exp_mem_rdata) begin
                        miscompares++;
                        $display("FAIL rand_mem_rdata it=%0d: got %h want %h", it, bus.mem_rdata,
                                 exp_mem_rdata);
                    end
                    bus.mem_req = 1'b0;
                    mem_pend    = 1'b0;
                end
                if (k == if_at) begin
                    vectors++;
                    if (bus.if_rdata !== ref_mem[iw]) begin
                        miscompares++;
                        $display("FAIL rand_if_rdata it=%0d: got %h want %h", it, bus.if_rdata,
                                 ref_mem[iw]);
                    end
                    bus.if_req = 1'b0;
                    if_pend    = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_sel   = 4'h0;
        bus.mem_wdata = 32'h0;
        bus1.if_req    = 1'b0;
        bus1.if_addr   = 32'h0;
        bus1.mem_req   = 1'b0;
        bus1.mem_we    = 1'b0;
        bus1.mem_addr  = 32'h0;
        bus1.mem_sel   = 4'h0;
        bus1.mem_wdata = 32'h0;

        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_single_cycle();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
